// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer: FSM states,
// command-byte layout and the saturating error-counter helper.
package spi_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_FETCH = 3'd3,
    ST_LOAD  = 3'd4
  } state_e;

  localparam int         CMD_RW_BIT = 7;
  localparam logic [7:0] ERR_MAX    = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Byte stream from the SPI slave plus the register/pixel memory port.
// master = sequencer side, slave = SPI slave / memory side.
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_load;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    input  rx_valid, rx_data, mem_rdata,
    output tx_load, tx_data, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data, mem_rdata,
    input  tx_load, tx_data, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/spi_cmd_ctrl_cs_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses; level and pulses
// are aligned and appear 3 clk_sb after the pin. Resets to "high" (deselected).
module spi_cmd_ctrl_cs_sync_edge (
  input  logic clk_sb,
  input  logic reset_n,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, hist_q, rise_q, fall_q;

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
      rise_q <= sync_q & ~hist_q;
      fall_q <= ~sync_q & hist_q;
    end
  end

  assign lvl_o  = hist_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI frame decoder: command byte then write data, or a read staged for the next frame's MISO load.
// SPI_CTRL_AUTOINC_EN: step the address after each write byte / fetch (wraps); otherwise hold it.
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic           clk_sb,
  input  logic           reset_n,
  input  logic           cs_n_i,
  spi_cmd_ctrl_if.master bus,
  output logic           frame_done_o,
  output logic [7:0]     err_cnt_o
);

  localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

  logic cs_hi, cs_rise, cs_fall;

  spi_cmd_ctrl_cs_sync_edge u_cs_sync (
    .clk_sb (clk_sb),
    .reset_n(reset_n),
    .din_i  (cs_n_i),
    .lvl_o  (cs_hi),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_step;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        lat_cnt_q;
  logic              mem_we_q, mem_re_q, tx_load_q, frame_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q, tx_data_q, err_cnt_q;
  logic              err_inc;

`ifdef SPI_CTRL_AUTOINC_EN
  assign addr_step = addr_q + ADDR_W'(1);
`else
  assign addr_step = addr_q;
`endif

  assign cmd_addr = bus.rx_data[ADDR_W-1:0];

  // Stray byte outside a frame, or a new frame arriving before a pending read was loaded.
  assign err_inc = ((state_q == ST_IDLE) && bus.rx_valid) ||
                   (((state_q == ST_FETCH) || (state_q == ST_LOAD)) && cs_fall);

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      lat_cnt_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tx_data_q    <= '0;
      tx_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      tx_load_q    <= 1'b0;
      frame_done_q <= cs_rise;
      if (err_inc) err_cnt_q <= sat_inc(err_cnt_q);

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_q <= ST_CMD;
        end
        ST_CMD: begin
          if (bus.rx_valid) begin
            addr_q <= cmd_addr;
            if (bus.rx_data[CMD_RW_BIT]) begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= cmd_addr;
              lat_cnt_q  <= '0;
              state_q    <= ST_FETCH;
            end else begin
              state_q <= cs_rise ? ST_IDLE : ST_WDATA;
            end
          end else if (cs_rise) begin
            state_q <= ST_IDLE;
          end
        end
        ST_WDATA: begin
          // A byte landing with the frame close is still written before going idle.
          if (bus.rx_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= bus.rx_data;
            addr_q      <= addr_step;
          end
          if (cs_rise)      state_q <= ST_IDLE;
          else if (cs_fall) state_q <= ST_CMD;
        end
        ST_FETCH: begin
          if (cs_fall) begin
            state_q <= ST_CMD;
          end else if (lat_cnt_q == RD_LAT_C) begin
            tx_data_q <= bus.mem_rdata;
            addr_q    <= addr_step;
            state_q   <= ST_LOAD;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        ST_LOAD: begin
          if (cs_fall) begin
            state_q <= ST_CMD;
          end else if (cs_hi) begin
            tx_load_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_load   = tx_load_q;
  assign frame_done_o  = frame_done_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomised frame-level bench for spi_cmd_ctrl against a transaction model
// (expected writes, reads, loads, frame ends and error count per frame).
module tb_spi_cmd_ctrl;

  localparam int ADDR_W = 7;
  localparam int RD_LAT = 2;

  logic       clk_sb  = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n    = 1'b1;
  logic       frame_done;
  logic [7:0] err_cnt;

  spi_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  spi_cmd_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_sb      (clk_sb),
    .reset_n     (reset_n),
    .cs_n_i      (cs_n),
    .bus         (bus),
    .frame_done_o(frame_done),
    .err_cnt_o   (err_cnt)
  );

  always #5 clk_sb = ~clk_sb;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed and expected transactions
  logic [15:0]       obs_wr[$], exp_wr[$];
  logic [ADDR_W-1:0] obs_rd[$], exp_rd[$];
  logic [7:0]        obs_ld[$], exp_ld[$];
  int                fd_obs = 0, fd_exp = 0, err_exp = 0;
  logic [7:0]        tb_mem[128];
  logic [7:0]        ref_mem[128];
  logic [7:0]        dbuf[4];

  int                rd_cnt = 0;
  logic [ADDR_W-1:0] rd_addr = '0;

  // Memory responder and monitor, both on the falling edge
  initial begin
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk_sb);
      if (rd_cnt > 0) begin
        rd_cnt--;
        bus.mem_rdata = (rd_cnt == 0) ? tb_mem[rd_addr] : 8'($urandom);
      end else begin
        bus.mem_rdata = 8'($urandom);
      end
      if (bus.mem_we || bus.mem_re) check("we_re_excl", 32'(bus.mem_we & bus.mem_re), 32'd0);
      if (bus.mem_we) begin
        obs_wr.push_back({1'b0, bus.mem_addr, bus.mem_wdata});
        tb_mem[bus.mem_addr] = bus.mem_wdata;
      end
      if (bus.mem_re) begin
        obs_rd.push_back(bus.mem_addr);
        rd_cnt  = RD_LAT;
        rd_addr = bus.mem_addr;
      end
      if (bus.tx_load) obs_ld.push_back(bus.tx_data);
      if (frame_done) fd_obs++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sb);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic err_bump();
    err_exp = (err_exp + 1 > 255) ? 255 : err_exp + 1;
  endtask

  task automatic stray(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom));
      tick($urandom_range(0, 2));
      err_bump();
    end
  endtask

  // Frame-level reference: what the frame must do to memory and MISO staging
  task automatic model_frame(input logic has_cmd, input logic [7:0] cmd, input int n);
    int a;
    fd_exp++;
    if (!has_cmd) return;
    a = int'(cmd[6:0]);
    if (cmd[7]) begin
      exp_rd.push_back(ADDR_W'(a));
      exp_ld.push_back(ref_mem[a]);
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back({1'b0, 7'(a), dbuf[i]});
        ref_mem[a] = dbuf[i];
`ifdef SPI_CTRL_AUTOINC_EN
        a = (a + 1) % 128;
`endif
      end
    end
  endtask

  // late=1: the final byte arrives in the same cycle the frame close is seen
  task automatic run_frame(input logic has_cmd, input logic [7:0] cmd, input int n, input logic late);
    logic [7:0] bytes[$];
    int nb;
    if (has_cmd) begin
      bytes.push_back(cmd);
      for (int i = 0; i < n; i++) bytes.push_back(dbuf[i]);
    end
    nb = bytes.size();
    cs_n = 1'b0;
    tick(6 + $urandom_range(0, 3));
    for (int i = 0; i < nb - 1; i++) begin
      send_byte(bytes[i]);
      tick($urandom_range(0, 3));
    end
    if (nb > 0 && late) begin
      cs_n = 1'b1;
      tick(3);
      send_byte(bytes[nb-1]);
    end else begin
      if (nb > 0) begin
        send_byte(bytes[nb-1]);
        tick($urandom_range(1, 3));
      end
      cs_n = 1'b1;
    end
    tick(12);
    model_frame(has_cmd, cmd, n);
  endtask

  task automatic verify(input string tag);
    check({tag, "/wr_count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check({tag, "/wr_addr_data"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
    check({tag, "/rd_count"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      check({tag, "/rd_addr"}, 32'(obs_rd[i]), 32'(exp_rd[i]));
    check({tag, "/load_count"}, 32'(obs_ld.size()), 32'(exp_ld.size()));
    for (int i = 0; i < exp_ld.size() && i < obs_ld.size(); i++)
      check({tag, "/load_data"}, 32'(obs_ld[i]), 32'(exp_ld[i]));
    check({tag, "/frame_done"}, 32'(fd_obs), 32'(fd_exp));
    check({tag, "/err_cnt"}, 32'(err_cnt), 32'(err_exp));
    obs_wr.delete(); exp_wr.delete();
    obs_rd.delete(); exp_rd.delete();
    obs_ld.delete(); exp_ld.delete();
  endtask

  logic [7:0]        v;
  int                kind;
  logic              late;
  logic [6:0]        addr;

  initial begin
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick(3);
    check("rst/tx_load",    32'(bus.tx_load),   32'd0);
    check("rst/tx_data",    32'(bus.tx_data),   32'd0);
    check("rst/mem_we",     32'(bus.mem_we),    32'd0);
    check("rst/mem_re",     32'(bus.mem_re),    32'd0);
    check("rst/mem_addr",   32'(bus.mem_addr),  32'd0);
    check("rst/mem_wdata",  32'(bus.mem_wdata), 32'd0);
    check("rst/frame_done", 32'(frame_done),    32'd0);
    check("rst/err_cnt",    32'(err_cnt),       32'd0);
    reset_n = 1'b1;
    tick(3);

    dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
    run_frame(1'b1, 8'h05, 2, 1'b0);
    verify("wr05");

    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    run_frame(1'b1, 8'h7F, 2, 1'b0);
    verify("wrap7F");

    tb_mem[3] = 8'h3C; ref_mem[3] = 8'h3C;
    run_frame(1'b1, 8'h83, 0, 1'b0);
    verify("rd83");
    check("rd83/tx_data", 32'(bus.tx_data), 32'h3C);

    dbuf[0] = 8'h5A; dbuf[1] = 8'hC3; dbuf[2] = 8'h0F;
    run_frame(1'b1, 8'h20, 3, 1'b1);
    verify("late_wr");

    run_frame(1'b1, 8'h85, 0, 1'b1);
    verify("rise_in_fetch");

    run_frame(1'b0, 8'h00, 0, 1'b0);
    verify("empty_frame");

    // Short deselect pulse overlapping the fetch: read aborted, next command still accepted
    cs_n = 1'b0;
    tick(7);
    bus.rx_data  = 8'h80 | 8'h44;
    bus.rx_valid = 1'b1;
    cs_n         = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    cs_n         = 1'b0;
    tick(8);
    send_byte(8'h10);
    send_byte(8'h77);
    tick(2);
    cs_n = 1'b1;
    tick(12);
    exp_rd.push_back(ADDR_W'(7'h44));
    err_bump();
    fd_exp++;
    dbuf[0] = 8'h77;
    model_frame(1'b1, 8'h10, 1);
    verify("abort");

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      late = ($urandom_range(0, 3) == 0);
      addr = 7'($urandom_range(0, 127));
      for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
      case (kind)
        0, 1: run_frame(($urandom_range(0, 7) != 0), {1'b0, addr}, $urandom_range(0, 4), late);
        2:    run_frame(1'b1, {1'b1, addr}, $urandom_range(0, 2), late);
        default: begin
          stray($urandom_range(1, 3));
          run_frame(1'b1, {1'b0, addr}, $urandom_range(1, 4), late);
        end
      endcase
      verify("rand");
    end

    // Reset in the middle of a frame
    cs_n = 1'b0;
    tick(7);
    send_byte(8'h30);
    send_byte(8'h44);
    tick(2);
    reset_n = 1'b0;
    tick(2);
    check("rst_mid/err_cnt", 32'(err_cnt), 32'd0);
    reset_n = 1'b1;
    tick(4);
    cs_n = 1'b1;
    tick(12);
    err_exp = 0;
    dbuf[0] = 8'h44;
    model_frame(1'b1, 8'h30, 1);
    verify("rst_mid");

    stray(300);
    verify("saturate");
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("sat_reset/err_cnt", 32'(err_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
